// File: rtl/bb8051_ram_arb_if.sv
// bb8051_ram_arb_if: requester and RAM-side bus bundle for bb8051_ram_arb
interface bb8051_ram_arb_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [2:0] req, we, lock, gnt, rvalid;
    logic [ADDR_W-1:0] addr0, addr1, addr2, ram_addr;
    logic [DATA_W-1:0] wdata0, wdata1, wdata2, rdata, ram_wdata, ram_rdata;
    logic ram_en, ram_we, busy;
    modport master (
        output req, we, lock, addr0, addr1, addr2, wdata0, wdata1, wdata2, ram_rdata,
        input  gnt, rvalid, rdata, ram_en, ram_we, ram_addr, ram_wdata, busy
    );
    modport slave (
        input  req, we, lock, addr0, addr1, addr2, wdata0, wdata1, wdata2, ram_rdata,
        output gnt, rvalid, rdata, ram_en, ram_we, ram_addr, ram_wdata, busy
    );
endinterface

// File: rtl/bb8051_ram_arb.sv
// bb8051_ram_arb: three-way arbiter/sequencer for the bb8051 single-port internal data RAM
// Define BB8051_RAM_ARB_RR_EN to round-robin between requesters 1 and 2 below requester 0.
module bb8051_ram_arb #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int STARVE_LIM = 4
) (
    input logic clk,
    input logic rst,
    bb8051_ram_arb_if.slave bus
);
    typedef enum logic [1:0] {UNLOCKED, LOCKED0, LOCKED1, LOCKED2} state_t;
    localparam logic [3:0] LIM = 4'(STARVE_LIM);
    state_t state, state_nxt;
    logic [3:0] cnt1, cnt2;
    logic [2:0] gnt, owner_oh, rd_pend, rvalid_q;
    logic [1:0] sel;
    logic xfer, busy, we_sel, lock_sel, starve1, starve2, rr_pick2;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
`ifdef BB8051_RAM_ARB_RR_EN
    logic ptr;
    assign rr_pick2 = ptr;
    // ptr=1 favours requester 2 on the next 1/2 conflict
    always_ff @(posedge clk) begin
        if (!rst) ptr <= 1'b0;
        else if (gnt[1]) ptr <= 1'b1;
        else if (gnt[2]) ptr <= 1'b0;
    end
`else
    assign rr_pick2 = 1'b0;
`endif
    assign busy = state != UNLOCKED;
    assign owner_oh = state == LOCKED0 ? 3'b001 : state == LOCKED1 ? 3'b010 : state == LOCKED2 ? 3'b100 : 3'b000;
    assign starve1 = bus.req[1] && cnt1 == LIM;
    assign starve2 = bus.req[2] && cnt2 == LIM;
    always_comb begin
        gnt = 3'b000;
        if (rst) begin
            if (busy) gnt = bus.req & owner_oh;
            else if (starve1) gnt = 3'b010;
            else if (starve2) gnt = 3'b100;
            else if (bus.req[0]) gnt = 3'b001;
            else if (bus.req[1] && !(bus.req[2] && rr_pick2)) gnt = 3'b010;
            else if (bus.req[2]) gnt = 3'b100;
        end
    end
    assign xfer = |gnt;
    assign sel = gnt[2] ? 2'd2 : gnt[1] ? 2'd1 : 2'd0;
    assign we_sel = |(gnt & bus.we);
    assign lock_sel = |(gnt & bus.lock);
    assign sel_addr = sel == 2'd2 ? bus.addr2 : sel == 2'd1 ? bus.addr1 : bus.addr0;
    assign sel_wdata = sel == 2'd2 ? bus.wdata2 : sel == 2'd1 ? bus.wdata1 : bus.wdata0;
    always_comb begin
        state_nxt = state;
        if (xfer) state_nxt = lock_sel ? state_t'(sel + 2'd1) : UNLOCKED;
    end
    always_ff @(posedge clk) begin
        if (!rst) state <= UNLOCKED;
        else state <= state_nxt;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt1 <= 4'd0;
            cnt2 <= 4'd0;
            bus.ram_en <= 1'b0;
            bus.ram_we <= 1'b0;
            bus.ram_addr <= '0;
            bus.ram_wdata <= '0;
            rd_pend <= 3'b000;
            rvalid_q <= 3'b000;
        end else begin
            cnt1 <= (!bus.req[1] || gnt[1]) ? 4'd0 : cnt1 == LIM ? cnt1 : cnt1 + 4'd1;
            cnt2 <= (!bus.req[2] || gnt[2]) ? 4'd0 : cnt2 == LIM ? cnt2 : cnt2 + 4'd1;
            bus.ram_en <= xfer;
            bus.ram_we <= we_sel;
            if (xfer) begin
                bus.ram_addr <= sel_addr;
                bus.ram_wdata <= sel_wdata;
            end
            rd_pend <= gnt & ~bus.we;
            rvalid_q <= rd_pend;
        end
    end
    assign bus.gnt = gnt;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata = bus.ram_rdata;
    assign bus.busy = busy;
endmodule

// File: doc/bb8051_ram_arb.md
Name: bb8051_ram_arb

Overview:
- Arbiter and sequencer for the single-port internal data RAM of the bb8051 core.
- Shares the RAM between three requesters:
  - 0: ALU/writeback
  - 1: decoder operand fetch
  - 2: stack/indirect (@Ri, PUSH/POP)
- Issues one registered RAM command per cycle and returns read data with a 1-cycle RAM latency.
- Supports locked read-modify-write sequences (INC direct, XCH) and starvation promotion.

Parameters:
- ADDR_W, 8, RAM address width
- DATA_W, 8, RAM data width
- STARVE_LIM, 4, consecutive ungranted cycles after which requester 1 or 2 is promoted; legal 1..15

Ports:
- clk  in  1  core clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- req  in  3  per-requester access request (valid)
- we  in  3  per-requester write enable, qualifies req
- lock  in  3  per-requester lock: keep ownership after this transfer
- addr0, addr1, addr2  in  ADDR_W each  request address
- wdata0, wdata1, wdata2  in  DATA_W each  write data
- gnt  out  3  one-hot grant (ready), combinational
- rvalid  out  3  one-hot read-data-valid
- rdata  out  DATA_W  read data, equals ram_rdata
- ram_en  out  1  RAM command enable, registered
- ram_we  out  1  RAM write strobe, registered
- ram_addr  out  ADDR_W  RAM address, registered
- ram_wdata  out  DATA_W  RAM write data, registered
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after a read command
- busy  out  1  lock ownership active

Behaviour:
- Reset (rst=0 at clock edge):
  - ram_en, ram_we, ram_addr, ram_wdata, rvalid, busy, lock owner and starvation counters all clear to 0.
  - gnt is forced to 0 while rst=0.
  - A read in flight is dropped; its rvalid never asserts.
- Handshake:
  - A transfer on requester i occurs at a rising edge where req[i]=1 and gnt[i]=1.
  - A requester holds req, we, addr and wdata stable until that edge.
  - req may stay high for back-to-back transfers, up to one per cycle.
- Timing, transfer at edge N:
  - ram_en=1, ram_we=we[i], ram_addr=addr_i and ram_wdata=wdata_i during cycle N+1.
  - For a read, rvalid[i]=1 and rdata valid during cycle N+2.
  - Cycles with no transfer drive ram_en=0 and ram_we=0; ram_addr and ram_wdata hold their last value.
- gnt selection (combinational, at most one bit set, only to a requesting index):
  1. If a lock owner exists, only the owner can be granted.
  2. Otherwise, a starved requester wins. Starved means its counter has reached STARVE_LIM. If both 1 and 2 are starved, 1 wins.
  3. Otherwise, fixed priority 0 > 1 > 2.
- Starvation counters (requesters 1 and 2 only):
  - Increment each cycle req=1 and gnt=0.
  - Saturate at STARVE_LIM.
  - Clear on a transfer or when req=0.
  - Counting continues during another requester's lock.
- Lock FSM, states UNLOCKED and LOCKED(i):
  - UNLOCKED -> LOCKED(i) on a transfer from i with lock[i]=1.
  - LOCKED(i) -> UNLOCKED on a transfer from i with lock[i]=0.
  - While LOCKED(i), if req[i]=0 the arbiter stays LOCKED(i) and grants nothing. The requester is responsible for releasing the lock.
  - busy=1 in the cycle after entry through the cycle of the releasing transfer's edge, i.e. registered state is LOCKED.
  - Re-lock from the same owner stays LOCKED.
- Simultaneous events:
  - A read and a write to the same address in consecutive cycles are executed in grant order; the RAM gives write-first-by-order, with no bypass.
  - lock asserted with req=0 is ignored.

Optional Feature:
- Macro: BB8051_RAM_ARB_RR_EN
- Defined:
  - Priority rule 3 becomes 0 > round-robin(1,2).
  - A 1-bit pointer selects 1 or 2 on conflict and toggles to the other after each transfer from 1 or 2.
  - Pointer resets to 1.
  - Starvation and lock rules are unchanged.
- Not defined: fixed 0 > 1 > 2; no pointer register exists.

Test Plan:
- Reset check: reset asserted for 2 cycles with req=3'b111 -> gnt=0, ram_en=0 and rvalid=0 throughout. After release, first gnt=3'b001.
- Concurrent read and write: requester 1 reads addr 8'h30 and requester 0 writes 8'h30<=8'hA5 in the same cycle N.
  - gnt=001 at N; ram_we=1 and ram_addr=30 at N+1.
  - Requester 1 is then granted; its read command is at N+2 and rvalid[1]=1 with rdata=A5 at N+3.
- Starvation: req0 held high continuously while req2 is high, STARVE_LIM=4 -> requester 2 is granted exactly on the 5th cycle, then requester 0 resumes.
- Locked read-modify-write: requester 2 reads 8'h40 with lock=1, then writes 8'h41 with lock=0, while req0 is high throughout.
  - No gnt[0] between the two transfers.
  - busy=1 for exactly the span in between.
  - gnt[0] asserts the cycle after the write.
- Reset during lock: rst low one cycle while LOCKED(1) with a read in flight -> busy=0 and no rvalid after reset. The next cycle's gnt follows fixed priority.
- With BB8051_RAM_ARB_RR_EN defined: req1 and req2 held high for 4 cycles, req0=0 -> grant sequence 1, 2, 1, 2. Without the macro -> 1, 1, 1, 1 until requester 2 starves.
